abacus_instruction_profiler: RTL and testbench

- Counts retired/issued instructions by class, from the core's issue tap (`instruction`, `instruction_issued`).
- Presents eleven per-class counters directly to the ABACUS top-level. The top-level maps them read-only onto its Wishbone window.
- Two-stage pipeline: capture, then classify-and-increment. Includes a synchronous clear, optional saturation and sticky per-counter overflow flags.

---
 rtl/abacus_instruction_profiler_pkg.sv | 45 ++++
 rtl/abacus_instruction_profiler_if.sv | 37 +++
 rtl/abacus_instruction_classifier.sv | 56 +++++
 rtl/abacus_instruction_profiler.sv | 91 +++++++++
 tb/tb_abacus_instruction_profiler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/abacus_instruction_profiler_pkg.sv
// Shared definitions for the ABACUS profilers: RV32 opcodes, the
// instruction class enumeration and a class-to-one-hot helper.
package abacus_pkg;

  localparam int NUM_CLASSES = 11;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_AMO      = 7'b0101111;

  // Enumeration order (minus one) is the counter index and overflow bit.
  typedef enum logic [3:0] {
    CLS_NONE   = 4'd0,
    CLS_LOAD   = 4'd1,
    CLS_STORE  = 4'd2,
    CLS_ADD    = 4'd3,
    CLS_SUB    = 4'd4,
    CLS_LOGIC  = 4'd5,
    CLS_SHIFT  = 4'd6,
    CLS_CMP    = 4'd7,
    CLS_BRANCH = 4'd8,
    CLS_JUMP   = 4'd9,
    CLS_SYSTEM = 4'd10,
    CLS_ATOMIC = 4'd11
  } instr_class_t;

  // One-hot counter select for a class; CLS_NONE selects nothing.
  function automatic logic [NUM_CLASSES-1:0] class_onehot(instr_class_t c);
    logic [NUM_CLASSES-1:0] oh;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      oh[k] = (int'(c) == k + 1);
    end
    return oh;
  endfunction

endpackage

// File: rtl/abacus_instruction_profiler_if.sv
// Issue-tap inputs and per-class counter outputs of the profiler.
interface abacus_instruction_profiler_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic                     enable;
  logic                     clear;
  logic                     instruction_issued;
  logic [31:0]              instruction;
  logic [COUNTER_WIDTH-1:0] load_word_counter;
  logic [COUNTER_WIDTH-1:0] store_word_counter;
  logic [COUNTER_WIDTH-1:0] addition_counter;
  logic [COUNTER_WIDTH-1:0] subtraction_counter;
  logic [COUNTER_WIDTH-1:0] logical_bitwise_counter;
  logic [COUNTER_WIDTH-1:0] shift_bitwise_counter;
  logic [COUNTER_WIDTH-1:0] comparison_counter;
  logic [COUNTER_WIDTH-1:0] branch_counter;
  logic [COUNTER_WIDTH-1:0] jump_counter;
  logic [COUNTER_WIDTH-1:0] system_privilege_counter;
  logic [COUNTER_WIDTH-1:0] atomic_counter;
  logic [10:0]              overflow;

  modport master (
    output enable, clear, instruction_issued, instruction,
    input  load_word_counter, store_word_counter, addition_counter,
           subtraction_counter, logical_bitwise_counter, shift_bitwise_counter,
           comparison_counter, branch_counter, jump_counter,
           system_privilege_counter, atomic_counter, overflow
  );

  modport slave (
    input  enable, clear, instruction_issued, instruction,
    output load_word_counter, store_word_counter, addition_counter,
           subtraction_counter, logical_bitwise_counter, shift_bitwise_counter,
           comparison_counter, branch_counter, jump_counter,
           system_privilege_counter, atomic_counter, overflow
  );
endinterface

// File: rtl/abacus_instruction_classifier.sv
// Combinational RV32IA instruction classifier; M-extension and unknown
// encodings map to CLS_NONE.
module abacus_instruction_classifier
  import abacus_pkg::*;
(
  input  logic [31:0]  instruction_i,
  output instr_class_t instr_class_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_zero;
  logic       f7_alt;

  assign opc     = instruction_i[6:0];
  assign f3      = instruction_i[14:12];
  assign f7      = instruction_i[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);

  // Decode opcode, then funct3/funct7 for the OP and OP-IMM groups.
  always_comb begin
    instr_class_o = CLS_NONE;
    case (opc)
      OPC_LOAD:                     instr_class_o = CLS_LOAD;
      OPC_STORE:                    instr_class_o = CLS_STORE;
      OPC_LUI, OPC_AUIPC:           instr_class_o = CLS_ADD;
      OPC_BRANCH:                   instr_class_o = CLS_BRANCH;
      OPC_JAL, OPC_JALR:            instr_class_o = CLS_JUMP;
      OPC_SYSTEM, OPC_MISC_MEM:     instr_class_o = CLS_SYSTEM;
      OPC_AMO:                      instr_class_o = CLS_ATOMIC;
      OPC_OP: begin
        case (f3)
          3'b000: begin
            if (f7_zero)     instr_class_o = CLS_ADD;
            else if (f7_alt) instr_class_o = CLS_SUB;
          end
          3'b100, 3'b110, 3'b111: if (f7_zero) instr_class_o = CLS_LOGIC;
          3'b001, 3'b101:  if (f7_zero || f7_alt) instr_class_o = CLS_SHIFT;
          default:         if (f7_zero) instr_class_o = CLS_CMP;
        endcase
      end
      OPC_OP_IMM: begin
        case (f3)
          3'b000:                 instr_class_o = CLS_ADD;
          3'b100, 3'b110, 3'b111: instr_class_o = CLS_LOGIC;
          3'b001, 3'b101: if (f7_zero || f7_alt) instr_class_o = CLS_SHIFT;
          default:                instr_class_o = CLS_CMP;
        endcase
      end
      default: instr_class_o = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/abacus_instruction_profiler.sv
// Two-stage instruction profiler: capture the issue tap, then classify
// and bump one of eleven per-class counters with sticky overflow flags.
module abacus_instruction_profiler
  import abacus_pkg::*;
#(
  parameter int   COUNTER_WIDTH = 32,
  parameter logic SATURATE      = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  abacus_instruction_profiler_if.slave  bus
);

  logic                     s1_valid_q;
  logic [31:0]              s1_instr_q;
  instr_class_t             s1_class;
  logic [NUM_CLASSES-1:0]   inc;
  logic [NUM_CLASSES-1:0]   ovf_w;
  logic [COUNTER_WIDTH-1:0] cnt_w [NUM_CLASSES];

  // Stage 1: enable is sampled only here, so a captured instruction is
  // counted even if enable drops afterwards. Clear does not flush it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
    end else begin
      s1_valid_q <= bus.instruction_issued & bus.enable;
      s1_instr_q <= bus.instruction;
    end
  end

  abacus_instruction_classifier u_classifier (
    .instruction_i (s1_instr_q),
    .instr_class_o (s1_class)
  );

  assign inc = s1_valid_q ? class_onehot(s1_class) : '0;

  // Stage 2: one counter slice per class.
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cnt
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;

    // Clear beats increment; an increment at all-ones flags overflow and
    // either holds or wraps.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (bus.clear) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (inc[gi]) begin
        if (&cnt_q) begin
          ovf_d = 1'b1;
          cnt_d = SATURATE ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign cnt_w[gi] = cnt_q;
    assign ovf_w[gi] = ovf_q;
  end

  assign bus.load_word_counter        = cnt_w[0];
  assign bus.store_word_counter       = cnt_w[1];
  assign bus.addition_counter         = cnt_w[2];
  assign bus.subtraction_counter      = cnt_w[3];
  assign bus.logical_bitwise_counter  = cnt_w[4];
  assign bus.shift_bitwise_counter    = cnt_w[5];
  assign bus.comparison_counter       = cnt_w[6];
  assign bus.branch_counter           = cnt_w[7];
  assign bus.jump_counter             = cnt_w[8];
  assign bus.system_privilege_counter = cnt_w[9];
  assign bus.atomic_counter           = cnt_w[10];
  assign bus.overflow                 = ovf_w;

endmodule

// File: tb/tb_abacus_instruction_profiler.sv
// Directed bench: a 32-bit saturating profiler checked against a counter
// model, plus two 4-bit instances for saturate and wrap behaviour.
module tb_abacus_instruction_profiler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic        issued;
  logic [31:0] instr;

  always #5 clk = ~clk;

  abacus_instruction_profiler_if #(.COUNTER_WIDTH(32)) m_if ();
  abacus_instruction_profiler_if #(.COUNTER_WIDTH(4))  s_if ();
  abacus_instruction_profiler_if #(.COUNTER_WIDTH(4))  w_if ();

  assign m_if.enable = enable;  assign m_if.clear = clear;
  assign m_if.instruction_issued = issued;  assign m_if.instruction = instr;
  assign s_if.enable = enable;  assign s_if.clear = clear;
  assign s_if.instruction_issued = issued;  assign s_if.instruction = instr;
  assign w_if.enable = enable;  assign w_if.clear = clear;
  assign w_if.instruction_issued = issued;  assign w_if.instruction = instr;

  abacus_instruction_profiler #(.COUNTER_WIDTH(32), .SATURATE(1'b1)) u_main (
    .clk (clk), .rst (rst), .bus (m_if)
  );
  abacus_instruction_profiler #(.COUNTER_WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk (clk), .rst (rst), .bus (s_if)
  );
  abacus_instruction_profiler #(.COUNTER_WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk (clk), .rst (rst), .bus (w_if)
  );

  logic [31:0] dut_cnt [11];
  assign dut_cnt[0]  = m_if.load_word_counter;
  assign dut_cnt[1]  = m_if.store_word_counter;
  assign dut_cnt[2]  = m_if.addition_counter;
  assign dut_cnt[3]  = m_if.subtraction_counter;
  assign dut_cnt[4]  = m_if.logical_bitwise_counter;
  assign dut_cnt[5]  = m_if.shift_bitwise_counter;
  assign dut_cnt[6]  = m_if.comparison_counter;
  assign dut_cnt[7]  = m_if.branch_counter;
  assign dut_cnt[8]  = m_if.jump_counter;
  assign dut_cnt[9]  = m_if.system_privilege_counter;
  assign dut_cnt[10] = m_if.atomic_counter;

  string cname [11] = '{"load", "store", "add", "sub", "logic", "shift",
                        "cmp", "branch", "jump", "system", "atomic"};

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_cnt [11];

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] ADD  = 32'h002081B3;

  typedef struct {
    logic [31:0] ins;
    int          cls;   // expected counter index, -1 = unclassified
    string       nm;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("%s %s", tag, cname[i]), dut_cnt[i], exp_cnt[i]);
    end
    chk($sformatf("%s overflow", tag), {21'b0, m_if.overflow}, 32'h0);
  endtask

  task automatic model_zero();
    for (int i = 0; i < 11; i++) exp_cnt[i] = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_zero();
  endtask

  initial begin
    vecs[0]  = '{32'h00500093,  2, "ADDI"};
    vecs[1]  = '{32'h0000A103,  0, "LW"};
    vecs[2]  = '{32'h00112023,  1, "SW"};
    vecs[3]  = '{32'h002081B3,  2, "ADD"};
    vecs[4]  = '{32'h402081B3,  3, "SUB"};
    vecs[5]  = '{32'h0020F1B3,  4, "AND"};
    vecs[6]  = '{32'h0010C093,  4, "XORI"};
    vecs[7]  = '{32'h00109093,  5, "SLLI"};
    vecs[8]  = '{32'h4020D1B3,  5, "SRA"};
    vecs[9]  = '{32'h402091B3,  5, "SLL_f7alt"};
    vecs[10] = '{32'h0020A1B3,  6, "SLT"};
    vecs[11] = '{32'h0010B093,  6, "SLTIU"};
    vecs[12] = '{32'h00208463,  7, "BEQ"};
    vecs[13] = '{32'h0000006F,  8, "JAL"};
    vecs[14] = '{32'h000080E7,  8, "JALR"};
    vecs[15] = '{32'h00000073,  9, "ECALL"};
    vecs[16] = '{32'h0000000F,  9, "FENCE"};
    vecs[17] = '{32'h0020A1AF, 10, "AMOADD"};
    vecs[18] = '{32'h000120B7,  2, "LUI"};
    vecs[19] = '{32'h022081B3, -1, "MUL"};
    vecs[20] = '{32'hFFFFFFFF, -1, "ALL_ONES"};
    vecs[21] = '{32'h0220C1B3, -1, "M_ext_f3_100"};

    rst = 1'b0; enable = 1'b1; clear = 1'b0; issued = 1'b0; instr = '0;
    model_zero();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_main("reset");
    $display("reset released, counters checked");

    // Single-instruction vectors, two edges of latency each.
    for (int v = 0; v < 22; v++) begin
      instr = vecs[v].ins; issued = 1'b1;
      tick();
      issued = 1'b0;
      tick();
      if (vecs[v].cls >= 0) exp_cnt[vecs[v].cls]++;
      $display("vec %0d %s instr=%08h class=%0d", v, vecs[v].nm, vecs[v].ins, vecs[v].cls);
      check_main(vecs[v].nm);
    end

    // Back-to-back issue with no bubbles.
    do_clear();
    begin
      logic [31:0] seq [6];
      int          cls [6];
      seq = '{32'h0000A103, 32'h402081B3, 32'h00208463,
              32'h0000006F, 32'h00000073, 32'h0020A1AF};
      cls = '{0, 3, 7, 8, 9, 10};
      issued = 1'b1;
      for (int k = 0; k < 6; k++) begin
        instr = seq[k];
        tick();
        exp_cnt[cls[k]]++;
      end
      issued = 1'b0;
      tick();
    end
    $display("back-to-back burst of 6");
    check_main("b2b");

    // Enable gating: nothing captured while disabled.
    instr = ADDI; issued = 1'b1; enable = 1'b0;
    repeat (10) tick();
    issued = 1'b0;
    repeat (2) tick();
    $display("10 ADDI with enable=0");
    check_main("en_off");

    // Captured while enabled, then enable drops: still counted.
    enable = 1'b1; issued = 1'b1; instr = ADDI;
    tick();
    enable = 1'b0; issued = 1'b0;
    tick();
    exp_cnt[2]++;
    $display("ADDI then enable drop");
    check_main("en_drop");
    enable = 1'b1;

    // Clear wins over a stage-2 increment; stage 1 keeps its capture.
    do_clear();
    instr = ADD; issued = 1'b1;
    repeat (5) tick();
    issued = 1'b0;
    tick();
    exp_cnt[2] = 5;
    check_main("pre_clear");
    issued = 1'b1;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0; issued = 1'b0;
    model_zero();
    $display("clear with ADD in stage 2 and ADD in stage 1");
    check_main("clear_prio");
    tick();
    exp_cnt[2] = 1;
    check_main("after_clear");

    // Saturation and wrap on 4-bit counters.
    do_clear();
    instr = ADDI; issued = 1'b1;
    repeat (17) tick();
    issued = 1'b0;
    tick();
    exp_cnt[2] = 17;
    $display("17 ADDI into 4-bit saturate/wrap instances");
    check_main("main17");
    chk("sat add",   {28'b0, s_if.addition_counter}, 32'hF);
    chk("sat ovf",   {21'b0, s_if.overflow},         32'h004);
    chk("sat load",  {28'b0, s_if.load_word_counter}, 32'h0);
    chk("wrap add",  {28'b0, w_if.addition_counter}, 32'h1);
    chk("wrap ovf",  {21'b0, w_if.overflow},         32'h004);
    repeat (2) tick();
    chk("sat ovf sticky",  {21'b0, s_if.overflow}, 32'h004);
    chk("wrap ovf sticky", {21'b0, w_if.overflow}, 32'h004);
    do_clear();
    chk("sat ovf cleared",  {21'b0, s_if.overflow}, 32'h0);
    chk("wrap ovf cleared", {21'b0, w_if.overflow}, 32'h0);
    chk("sat add cleared",  {28'b0, s_if.addition_counter}, 32'h0);

    // Asynchronous reset discards the in-flight stage-1 instruction.
    instr = ADD; issued = 1'b1;
    tick();
    issued = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
    tick();
    model_zero();
    $display("reset with ADD in flight");
    check_main("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
